mipi_csi_tx: RTL and testbench

- Two-lane MIPI CSI-2 byte-level packet transmitter. It is the transmit counterpart of MIPI_Reciever.
- Builds FS/FE short packets and long packets: HS-prepare, sync byte, header with ECC, payload, CRC-16, trail.
- Emits one byte per lane per sys_clk to a downstream serializer/PHY. Primary use is loopback and bring-up stimulus for the receiver on the ulx3s top.

---
 rtl/mipi_csi_tx.sv | 210 +++++++++++++++++++++
 tb/tb_mipi_csi_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_tx.sv
// Two-lane CSI-2 byte-level packet transmitter. Sends FS/FE short packets
// and long packets (prepare, sync, header + ECC, payload, CRC-16, trail)
// one byte per lane per clock, for receiver loopback and bring-up.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PREP  | HS-zero on both lanes
// SYNC  | sync byte 0xB8 on both lanes
// HDR0  | DI on lane0, WC[7:0] on lane1
// HDR1  | WC[15:8] on lane0, ECC on lane1
// PAY   | payload word per cycle, pix_ready high
// CRC   | CRC-16 low byte on lane0, high byte on lane1
// TRAIL | inverted last bit of each lane, repeated
// GAP   | LP gap, hs_en low
module mipi_csi_tx #(
    parameter logic [1:0] VC           = 2'd0,
    parameter int         PREP_CYCLES  = 4,
    parameter int         TRAIL_CYCLES = 4,
    parameter int         GAP_CYCLES   = 8
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_dt,
    input  logic [15:0] cmd_wc,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  lane0_byte,
    output logic [7:0]  lane1_byte,
    output logic        hs_en,
    output logic        busy,
    output logic [15:0] frame_num,
    output logic        err_underflow
);

    typedef enum logic [3:0] {
        IDLE, PREP, SYNC, HDR0, HDR1, PAY, CRC, TRAIL, GAP
    } state_t;

    // Parity-bit coverage of the 24-bit header {WC hi, WC lo, DI}
    localparam logic [23:0] P0_MASK = 24'hF12CB7;
    localparam logic [23:0] P1_MASK = 24'hF2555B;
    localparam logic [23:0] P2_MASK = 24'h749A6D;
    localparam logic [23:0] P3_MASK = 24'hB8E38E;
    localparam logic [23:0] P4_MASK = 24'hDF03F0;
    localparam logic [23:0] P5_MASK = 24'hEFFC00;

    state_t      state;
    logic [14:0] cnt;
    logic [1:0]  typ_q;
    logic [5:0]  dt_q;
    logic [15:0] wc_q;
    logic [15:0] crc_q;
    logic [7:0]  lane0_q;
    logic [7:0]  lane1_q;

    logic        long_pkt;
    logic [7:0]  di;
    logic [15:0] wc_field;
    logic [23:0] hdr;
    logic [7:0]  ecc;
    logic [7:0]  pay0;
    logic [7:0]  pay1;
    logic [15:0] crc_pay;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign long_pkt = (typ_q == 2'd2);
    assign di       = long_pkt ? {VC, dt_q} : {VC, 5'd0, typ_q[0]};
    assign wc_field = long_pkt ? wc_q : frame_num;
    assign hdr      = {wc_field, di};
    assign ecc      = {2'b00, ^(hdr & P5_MASK), ^(hdr & P4_MASK), ^(hdr & P3_MASK),
                       ^(hdr & P2_MASK), ^(hdr & P1_MASK), ^(hdr & P0_MASK)};

    // A missing payload word is sent (and checksummed) as zeros so HS never stalls
    assign pay0    = pix_valid ? pix_data[7:0]  : 8'h00;
    assign pay1    = pix_valid ? pix_data[15:8] : 8'h00;
    assign crc_pay = crc_byte(crc_byte(crc_q, pay0), pay1);

    // Payload bytes pass straight through so the word accepted by pix_ready is the one on the lanes
    assign lane0_byte = (state == PAY) ? pay0 : lane0_q;
    assign lane1_byte = (state == PAY) ? pay1 : lane1_q;

    // Packet sequencer: state, timers and registered lane/handshake outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            typ_q         <= '0;
            dt_q          <= '0;
            wc_q          <= '0;
            crc_q         <= 16'hFFFF;
            lane0_q       <= 8'h00;
            lane1_q       <= 8'h00;
            hs_en         <= 1'b0;
            busy          <= 1'b0;
            cmd_ready     <= 1'b1;
            pix_ready     <= 1'b0;
            frame_num     <= 16'd1;
            err_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Reserved type is accepted but produces nothing
                    if (cmd_valid && cmd_type != 2'd3) begin
                        typ_q     <= cmd_type;
                        dt_q      <= cmd_dt;
                        wc_q      <= cmd_wc & 16'hFFFE;
                        state     <= PREP;
                        cnt       <= 15'(PREP_CYCLES - 1);
                        hs_en     <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        lane0_q   <= 8'h00;
                        lane1_q   <= 8'h00;
                    end
                end
                PREP: begin
                    if (cnt == '0) begin
                        state   <= SYNC;
                        lane0_q <= 8'hB8;
                        lane1_q <= 8'hB8;
                    end else begin
                        cnt <= cnt - 15'd1;
                    end
                end
                SYNC: begin
                    state   <= HDR0;
                    lane0_q <= di;
                    lane1_q <= wc_field[7:0];
                end
                HDR0: begin
                    state   <= HDR1;
                    lane0_q <= wc_field[15:8];
                    lane1_q <= ecc;
                    crc_q   <= 16'hFFFF;
                end
                HDR1: begin
                    if (typ_q == 2'd1)
                        frame_num <= (frame_num == 16'hFFFF) ? 16'd1 : frame_num + 16'd1;
                    if (long_pkt && wc_q[15:1] != '0) begin
                        state     <= PAY;
                        cnt       <= wc_q[15:1] - 15'd1;
                        pix_ready <= 1'b1;
                    end else if (long_pkt) begin
                        state   <= CRC;
                        lane0_q <= crc_q[7:0];
                        lane1_q <= crc_q[15:8];
                    end else begin
                        state   <= TRAIL;
                        cnt     <= 15'(TRAIL_CYCLES - 1);
                        lane0_q <= {8{~lane0_q[7]}};
                        lane1_q <= {8{~lane1_q[7]}};
                    end
                end
                PAY: begin
                    crc_q <= crc_pay;
                    if (!pix_valid) err_underflow <= 1'b1;
                    if (cnt == '0) begin
                        state     <= CRC;
                        pix_ready <= 1'b0;
                        lane0_q   <= crc_pay[7:0];
                        lane1_q   <= crc_pay[15:8];
                    end else begin
                        cnt <= cnt - 15'd1;
                    end
                end
                CRC: begin
                    state   <= TRAIL;
                    cnt     <= 15'(TRAIL_CYCLES - 1);
                    lane0_q <= {8{~lane0_q[7]}};
                    lane1_q <= {8{~lane1_q[7]}};
                end
                TRAIL: begin
                    if (cnt == '0) begin
                        state   <= GAP;
                        cnt     <= 15'(GAP_CYCLES - 1);
                        hs_en   <= 1'b0;
                        lane0_q <= 8'h00;
                        lane1_q <= 8'h00;
                    end else begin
                        cnt <= cnt - 15'd1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 15'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_tx.sv
// Self-checking bench for mipi_csi_tx: table of packet commands plus random
// packets, each compared cycle by cycle against a byte-stream model.
module tb_mipi_csi_tx;

    localparam int PREP = 4;
    localparam int TRAIL = 4;
    localparam int GAP = 8;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [5:0]  cmd_dt;
    logic [15:0] cmd_wc;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  lane0_byte;
    logic [7:0]  lane1_byte;
    logic        hs_en;
    logic        busy;
    logic [15:0] frame_num;
    logic        err_underflow;

    mipi_csi_tx dut (
        .sys_clk(sys_clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .lane0_byte(lane0_byte), .lane1_byte(lane1_byte), .hs_en(hs_en),
        .busy(busy), .frame_num(frame_num), .err_underflow(err_underflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  typ;
        logic [5:0]  dt;
        logic [15:0] wc;
        bit          use_ex;
        logic [31:0] gap_mask;   // bit k set: pix_valid low in payload cycle k
        bit          crc_known;
        logic [15:0] exp_crc;
    } vec_t;

    vec_t tbl [8];

    logic [7:0] ex_pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                                8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                                8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    // Syndrome contributed by each header bit {P5..P0}
    logic [5:0] syn [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                             6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                             6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] m_frame;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [5:0] s = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) s ^= syn[i];
        return {2'b00, s};
    endfunction

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    task automatic drive_pix(input vec_t v, input int k);
        pix_valid = (k < 32) ? !v.gap_mask[k] : 1'b1;
        if (v.use_ex && k < 12) pix_data = {ex_pay[2*k+1], ex_pay[2*k]};
        else                    pix_data = 16'($urandom);
    endtask

    task automatic run_pkt(input vec_t v);
        logic [7:0]  c0[$], c1[$], pk[$], e0[$], e1[$];
        logic [15:0] pw[$];
        logic [15:0] wcf, crc, w;
        logic [7:0]  di;
        logic        short_pkt, done;
        int          k, ngap, bad, npay, idx;
        short_pkt = (v.typ != 2'd2);
        di  = short_pkt ? {7'd0, v.typ[0]} : {2'd0, v.dt};
        wcf = short_pkt ? m_frame : (v.wc & 16'hFFFE);
        npay = short_pkt ? 0 : int'(wcf >> 1);
        k = 0; ngap = 0; done = 1'b0;

        @(posedge sys_clk); #1;
        cmd_valid = 1'b1; cmd_type = v.typ; cmd_dt = v.dt; cmd_wc = v.wc;
        @(negedge sys_clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            drive_pix(v, k);
            @(negedge sys_clk);
            if (pix_ready) begin
                pw.push_back(pix_valid ? pix_data : 16'h0000);
                k++;
            end
            if (hs_en) begin
                c0.push_back(lane0_byte);
                c1.push_back(lane1_byte);
            end else if (busy) begin
                ngap++;
            end
            if (!busy) done = 1'b1;
            else begin @(posedge sys_clk); #1; end
        end
        check("pkt_done", done, 1);

        // Expected packet bytes
        pk.push_back(di);
        pk.push_back(wcf[7:0]);
        pk.push_back(wcf[15:8]);
        pk.push_back(ecc_model({wcf, di}));
        if (!short_pkt) begin
            crc = 16'hFFFF;
            for (int i = 0; i < npay; i++) begin
                w = (i < pw.size()) ? pw[i] : 16'h0000;
                pk.push_back(w[7:0]);
                pk.push_back(w[15:8]);
                crc = crc_upd(crc, w[7:0]);
                crc = crc_upd(crc, w[15:8]);
                if (i < 32 && v.gap_mask[i]) m_err = 1'b1;
            end
            pk.push_back(crc[7:0]);
            pk.push_back(crc[15:8]);
        end
        for (int i = 0; i < PREP; i++) begin e0.push_back(8'h00); e1.push_back(8'h00); end
        e0.push_back(8'hB8); e1.push_back(8'hB8);
        for (int i = 0; i < pk.size(); i += 2) begin e0.push_back(pk[i]); e1.push_back(pk[i+1]); end
        for (int i = 0; i < TRAIL; i++) begin
            e0.push_back({8{~pk[pk.size()-2][7]}});
            e1.push_back({8{~pk[pk.size()-1][7]}});
        end

        check("hs_len", c0.size(), e0.size());
        bad = 0;
        for (int i = 0; i < c0.size() && i < e0.size(); i++) begin
            if (c0[i] !== e0[i] || c1[i] !== e1[i]) begin
                if (bad == 0)
                    $display("  first byte difference at hs cycle %0d: got %h/%h want %h/%h",
                             i, c0[i], c1[i], e0[i], e1[i]);
                bad++;
            end
        end
        check("hs_bytes", bad, 0);
        check("pix_ready_cnt", pw.size(), npay);
        check("gap_len", ngap, GAP);
        if (v.crc_known) begin
            idx = PREP + 3 + npay;
            check("crc_const", (c0.size() > idx) ? {c1[idx], c0[idx]} : 32'hFFFF_FFFF, v.exp_crc);
        end
        if (v.typ == 2'd1) m_frame = (m_frame == 16'hFFFF) ? 16'd1 : m_frame + 16'd1;
        check("frame_num", frame_num, m_frame);
        check("err_underflow", err_underflow, m_err);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   bad, seen;
        tbl[0] = '{2'd0, 6'h00, 16'd0,  1'b0, 32'h0, 1'b0, 16'h0};
        tbl[1] = '{2'd2, 6'h2B, 16'd24, 1'b1, 32'h0, 1'b1, 16'h00F0};
        tbl[2] = '{2'd2, 6'h2B, 16'd0,  1'b0, 32'h0, 1'b1, 16'hFFFF};
        tbl[3] = '{2'd1, 6'h00, 16'd0,  1'b0, 32'h0, 1'b0, 16'h0};
        tbl[4] = '{2'd2, 6'h1E, 16'd5,  1'b0, 32'h0, 1'b0, 16'h0};
        tbl[5] = '{2'd3, 6'h12, 16'd8,  1'b0, 32'h0, 1'b0, 16'h0};
        tbl[6] = '{2'd2, 6'h2A, 16'd16, 1'b0, 32'hC, 1'b0, 16'h0};
        tbl[7] = '{2'd0, 6'h00, 16'd0,  1'b0, 32'h0, 1'b0, 16'h0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_dt = 6'd0; cmd_wc = 16'd0;
        pix_data = 16'd0; pix_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_lanes", {lane1_byte, lane0_byte}, 16'h0000);
        check("rst_hs_en", hs_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_num", frame_num, 16'd1);
        check("rst_err", err_underflow, 0);
        @(posedge sys_clk); #1;
        reset = 1'b0;
        m_frame = 16'd1;
        m_err = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].typ == 2'd3) begin
                @(posedge sys_clk); #1;
                cmd_valid = 1'b1; cmd_type = 2'd3; cmd_dt = tbl[i].dt; cmd_wc = tbl[i].wc;
                @(negedge sys_clk);
                check("rsv_ready", cmd_ready, 1);
                @(posedge sys_clk); #1;
                cmd_valid = 1'b0;
                bad = 0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge sys_clk);
                    if (busy || hs_en || !cmd_ready) bad++;
                end
                check("rsv_no_output", bad, 0);
                check("rsv_frame", frame_num, m_frame);
            end else begin
                run_pkt(tbl[i]);
            end
        end

        for (int i = 0; i < 4; i++) begin
            v.typ       = 2'($urandom_range(0, 2));
            v.dt        = 6'($urandom);
            v.wc        = 16'($urandom_range(0, 60));
            v.use_ex    = 1'b0;
            v.gap_mask  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            v.crc_known = 1'b0;
            v.exp_crc   = 16'h0;
            run_pkt(v);
        end

        // Frame counter wrap: 0xFFFF -> 1 after the FE, never 0
        force dut.frame_num = 16'hFFFF;
        @(posedge sys_clk); #1;
        release dut.frame_num;
        @(negedge sys_clk);
        check("frame_forced", frame_num, 16'hFFFF);
        m_frame = 16'hFFFF;
        run_pkt(tbl[3]);
        run_pkt(tbl[0]);

        // Reset in the middle of a payload
        @(posedge sys_clk); #1;
        cmd_valid = 1'b1; cmd_type = 2'd2; cmd_dt = 6'h2B; cmd_wc = 16'd64;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0; pix_valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge sys_clk);
            if (pix_ready) seen++;
            @(posedge sys_clk); #1;
        end
        check("reached_pay", seen, 3);
        reset = 1'b1;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        @(negedge sys_clk);
        check("abort_hs_en", hs_en, 0);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_pix_ready", pix_ready, 0);
        check("abort_frame", frame_num, 16'd1);
        check("abort_err", err_underflow, 0);
        m_frame = 16'd1;
        m_err = 1'b0;
        run_pkt(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
